pkt_rd_engine: RTL and testbench
================================

# pkt_rd_engine

Read-side responder in the switch MMU for the per-port read command/data protocol. It accepts one read command at a time, containing `{firAddr, pageCnt, dstPort, dropFlag}`. It walks the packet's linked list of pages in the packet buffer and returns every beat as `{data, last}`, routed back to the requesting port. Every page it visits is released to the free-page manager. When `dropFlag` is set, it frees the pages without reading any data.

## Interface
Parameters:
- `DW`, 32: data beat width.
- `AW`, 11: page address width.
- `PAGE_BEATS`, 8: beats per page. Must be a power of 2 and at least 2.

Ports (clock and reset first; single clock; reset is asynchronous and active-low):
- `iClk`  in  1  clock.
- `iRst_n`  in  1  asynchronous active-low reset.
- `iRdCmd`  Decoupled.slave  Pld AW+9, Dst 4  read command. Pld = `{firAddr[AW-1:0], pageCnt[3:0], dstPort[3:0], dropFlag}`. `pageCnt` is the number of pages minus 1. Dst is ignored.
- `oRdData`  Decoupled.master  Pld DW+1, Dst 4  response beats. Pld = `{data, last}`. Dst = latched `dstPort`.
- `oFree`  Decoupled.master  Pld AW  page address returned to the free list.
- `oDataRdEn`  out  1  packet-buffer read strobe.
- `oDataRdAddr`  out  AW+log2(PAGE_BEATS)  read address `{page, beatIdx}`.
- `iDataRdData`  in  DW  read data, valid exactly 1 cycle after `oDataRdEn`.
- `oPtrRdEn`  out  1  next-pointer table read strobe.
- `oPtrRdAddr`  out  AW  page whose successor is read.
- `iPtrRdData`  in  AW  successor page, valid exactly 1 cycle after `oPtrRdEn`.

## Operation
- FSM states: IDLE, READ, DRAIN, DROP.
- IDLE:
  - `iRdCmd.Rdy = 1`.
  - On handshake, latch `curPage=firAddr`, `pagesLeft=pageCnt`, `dst`, `drop`, and `beatIdx=0`.
  - In the same cycle, issue a pointer read of `firAddr` if `pageCnt != 0`.
  - Next state is DROP if `dropFlag` is set, otherwise READ.
- Output buffer:
  - 2-entry FIFO between the SRAM return and `oRdData`.
  - `credit = 2 - fifoCount - inflight`.
  - A data read is issued only when `credit > 0`.
  - The SRAM is never stalled.
- READ:
  - Each cycle with credit and no stall: issue a read of `{curPage, beatIdx}`, then `beatIdx++`.
  - The beat is tagged `last` when `pagesLeft == 0 && beatIdx == PAGE_BEATS-1`.
  - Pointer data returned 1 cycle after a pointer read is latched into `nxtPage`, setting `nxtVld`.
- READ page boundary (issue of beat `PAGE_BEATS-1`):
  - `curPage` is loaded into a single free slot (`oFree.Vld`).
  - If the slot is still occupied, stall issue; no read this cycle.
  - If `pagesLeft != 0`: `curPage <= nxtPage`, `pagesLeft--`, `beatIdx <= 0`, and issue a pointer read of `nxtPage` if the new `pagesLeft != 0`.
  - On the last-beat issue, go to DRAIN.
- DRAIN:
  - Wait for the `last` beat handshake on `oRdData` and for the free slot to be empty.
  - Then go to IDLE.
- DROP:
  - No data reads are issued.
  - Each page is loaded into the free slot when the slot is empty and (`nxtVld` or `pagesLeft == 0`).
  - It then advances exactly as at a READ page boundary.
  - After the final page is loaded and accepted, go to IDLE.
  - `oRdData.Vld` stays 0 for the whole drop.
- Arithmetic:
  - `pagesLeft` is 4 bits and never decrements below 0.
  - `beatIdx` is log2(PAGE_BEATS) bits and wraps to 0 at each page boundary.
  - Page addresses are used as returned; no range check.
- Only one command is in flight. A new command is never accepted before the previous packet's last beat and last free have completed.

## Timing
- Reset values:
  - FSM = IDLE; `iRdCmd.Rdy = 1`.
  - `oRdData.Vld = 0`, `oFree.Vld = 0`, `oDataRdEn = 0`, `oPtrRdEn = 0`.
  - All addresses, FIFO contents, counters and `nxtVld` = 0.
- Latency: command handshake at cycle T, first `oDataRdEn` at T+1, first `oRdData.Vld` at T+2.
- Throughput:
  - With `oRdData.Rdy` and `oFree.Rdy` held high, 1 beat per cycle with no bubbles across page boundaries.
  - This holds because the pointer is prefetched at least `PAGE_BEATS-1` cycles early.
- Handshake:
  - Vld/Pld/Dst on `oRdData` and `oFree` are held stable until Rdy.
  - Vld never drops without a handshake.
- Backpressure: with `oRdData.Rdy = 0`, at most 2 beats are issued beyond the last accepted beat; no data is lost.
- Simultaneous events: a FIFO push and pop in the same cycle leave the count unchanged.
- Reset mid-packet: all state returns to reset values immediately. Pages not yet freed are not freed.

## Test plan
- Single page (`firAddr=0x010`, `pageCnt=0`, `dstPort=3`, no drop) -> 8 beats from addresses 0x080..0x087. `last` is set only on beat 7, Dst=3 on every beat, one `oFree` of 0x010, back in IDLE after the last handshake.
- Chain 0x010->0x2A5->0x003 (`pageCnt=2`), Rdy always high -> 24 consecutive beats with no gap and in address order. `oFree` carries 0x010, 0x2A5, 0x003 in order.
- Same chain with `oRdData.Rdy` toggling 1/0 and a 5-cycle low burst -> identical beat sequence, never more than 2 beats outstanding, no duplicates or losses.
- Drop (`firAddr=0x040`, `pageCnt=1`, next=0x041) -> zero `oRdData.Vld` and zero `oDataRdEn`. Frees 0x040 then 0x041; `iRdCmd.Rdy` returns to 1.
- `oFree.Rdy` held low for 10 cycles at the first page boundary -> data issue stalls and `oFree` holds 0x010 stable. The stream resumes without corruption when Rdy rises.
- Reset asserted at beat 12 of a 24-beat packet -> outputs at reset values that cycle. A new single-page command after release completes normally.

Source files
------------

// File: rtl/pkt_rd_engine.sv
// rtl/pkt_rd_engine.sv - packet read responder: walks a page chain, streams beats, frees pages
`timescale 1ns/1ps
module pkt_rd_engine #(
    parameter int DW         = 32,
    parameter int AW         = 11,
    parameter int PAGE_BEATS = 8
) (
    input  logic                                iClk,
    input  logic                                iRst_n,
    input  logic                                iRdCmdVld,
    output logic                                oRdCmdRdy,
    input  logic [AW+8:0]                       iRdCmdPld,
    input  logic [3:0]                          iRdCmdDst,
    output logic                                oRdDataVld,
    input  logic                                iRdDataRdy,
    output logic [DW:0]                         oRdDataPld,
    output logic [3:0]                          oRdDataDst,
    output logic                                oFreeVld,
    input  logic                                iFreeRdy,
    output logic [AW-1:0]                       oFreePld,
    output logic                                oDataRdEn,
    output logic [AW+$clog2(PAGE_BEATS)-1:0]    oDataRdAddr,
    input  logic [DW-1:0]                       iDataRdData,
    output logic                                oPtrRdEn,
    output logic [AW-1:0]                       oPtrRdAddr,
    input  logic [AW-1:0]                       iPtrRdData
);
    localparam int BW = $clog2(PAGE_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PAGE_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_page_q, cur_page_d;
    logic [AW-1:0]   nxt_page_q, nxt_page_d;
    logic [AW-1:0]   free_addr_q, free_addr_d;
    logic            nxt_vld_q, nxt_vld_d;
    logic            ptr_pend_q, ptr_pend_d;
    logic            free_vld_q, free_vld_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic            last_seen_q, last_seen_d;
    logic [3:0]      pages_left_q, pages_left_d;
    logic [3:0]      dst_q, dst_d;
    logic [BW-1:0]   beat_idx_q, beat_idx_d;
    logic [DW:0]     mem0_q, mem0_d, mem1_q, mem1_d;
    logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            data_rd_en, ptr_rd_en, page_step;
    logic [AW-1:0]   ptr_rd_addr;
    logic            fifo_has, data_hs, last_hs, push, pop;
    logic            credit_ok, slot_free, at_boundary, last_pg;
    logic [DW:0]     head;
    logic            unused_dst;

    assign unused_dst = ^iRdCmdDst;

    // Output buffer bypasses the SRAM return straight to the port when empty.
    assign fifo_has    = (count_q != 2'd0);
    assign head        = rd_ptr_q ? mem1_q : mem0_q;
    assign oRdDataVld  = fifo_has || inflight_q;
    assign oRdDataPld  = fifo_has ? head : {iDataRdData, inflight_last_q};
    assign oRdDataDst  = dst_q;
    assign data_hs     = oRdDataVld && iRdDataRdy;
    assign last_hs     = data_hs && oRdDataPld[0];
    assign push        = inflight_q && !(!fifo_has && iRdDataRdy);
    assign pop         = fifo_has && iRdDataRdy;
    assign credit_ok   = (count_q + {1'b0, inflight_q}) < 2'd2;
    assign slot_free   = !free_vld_q || iFreeRdy;
    assign at_boundary = (beat_idx_q == LAST_BEAT);
    assign last_pg     = (pages_left_q == 4'd0);

    assign oRdCmdRdy   = (state_q == S_IDLE);
    assign oFreeVld    = free_vld_q;
    assign oFreePld    = free_addr_q;
    assign oDataRdEn   = data_rd_en;
    assign oDataRdAddr = data_rd_en ? {cur_page_q, beat_idx_q} : '0;
    assign oPtrRdEn    = ptr_rd_en;
    assign oPtrRdAddr  = ptr_rd_addr;

    always_comb begin
        state_d         = state_q;
        cur_page_d      = cur_page_q;
        nxt_page_d      = nxt_page_q;
        nxt_vld_d       = nxt_vld_q;
        free_addr_d     = free_addr_q;
        free_vld_d      = free_vld_q && !iFreeRdy;
        pages_left_d    = pages_left_q;
        dst_d           = dst_q;
        beat_idx_d      = beat_idx_q;
        last_seen_d     = last_seen_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        data_rd_en      = 1'b0;
        ptr_rd_en       = 1'b0;
        ptr_rd_addr     = '0;
        page_step       = 1'b0;

        if (ptr_pend_q) begin
            nxt_page_d = iPtrRdData;
            nxt_vld_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (iRdCmdVld) begin
                    cur_page_d   = iRdCmdPld[AW+8:9];
                    pages_left_d = iRdCmdPld[8:5];
                    dst_d        = iRdCmdPld[4:1];
                    beat_idx_d   = '0;
                    nxt_vld_d    = 1'b0;
                    last_seen_d  = 1'b0;
                    if (iRdCmdPld[8:5] != 4'd0) begin
                        ptr_rd_en   = 1'b1;
                        ptr_rd_addr = iRdCmdPld[AW+8:9];
                    end
                    state_d = iRdCmdPld[0] ? S_DROP : S_READ;
                end
            end
            S_READ: begin
                if (credit_ok && (!at_boundary || (slot_free && (last_pg || nxt_vld_q)))) begin
                    data_rd_en      = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = last_pg && at_boundary;
                    beat_idx_d      = beat_idx_q + 1'b1;
                    if (at_boundary) begin
                        page_step = 1'b1;
                        if (last_pg) state_d = S_DRAIN;
                    end
                end
            end
            S_DROP: begin
                if (slot_free && (last_pg || nxt_vld_q)) begin
                    page_step = 1'b1;
                    if (last_pg) begin
                        last_seen_d = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_hs) last_seen_d = 1'b1;
                if ((last_seen_q || last_hs) && slot_free) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Release the current page and hop to its prefetched successor.
        if (page_step) begin
            free_vld_d  = 1'b1;
            free_addr_d = cur_page_q;
            if (!last_pg) begin
                cur_page_d   = nxt_page_q;
                pages_left_d = pages_left_q - 4'd1;
                beat_idx_d   = '0;
                nxt_vld_d    = 1'b0;
                if (pages_left_q != 4'd1) begin
                    ptr_rd_en   = 1'b1;
                    ptr_rd_addr = nxt_page_q;
                end
            end
        end
        ptr_pend_d = ptr_rd_en;
    end

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        if (push) begin
            if (wr_ptr_q) mem1_d = {iDataRdData, inflight_last_q};
            else          mem0_d = {iDataRdData, inflight_last_q};
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q         <= S_IDLE;
            cur_page_q      <= '0;
            nxt_page_q      <= '0;
            nxt_vld_q       <= 1'b0;
            ptr_pend_q      <= 1'b0;
            free_addr_q     <= '0;
            free_vld_q      <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            last_seen_q     <= 1'b0;
            pages_left_q    <= '0;
            dst_q           <= '0;
            beat_idx_q      <= '0;
            mem0_q          <= '0;
            mem1_q          <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            cur_page_q      <= cur_page_d;
            nxt_page_q      <= nxt_page_d;
            nxt_vld_q       <= nxt_vld_d;
            ptr_pend_q      <= ptr_pend_d;
            free_addr_q     <= free_addr_d;
            free_vld_q      <= free_vld_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            last_seen_q     <= last_seen_d;
            pages_left_q    <= pages_left_d;
            dst_q           <= dst_d;
            beat_idx_q      <= beat_idx_d;
            mem0_q          <= mem0_d;
            mem1_q          <= mem1_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end
endmodule

// File: tb/tb_pkt_rd_engine.sv
// tb/tb_pkt_rd_engine.sv - directed self-checking bench for pkt_rd_engine
`timescale 1ns/1ps
module tb_pkt_rd_engine;
    logic        clk, rst_n;
    logic        iRdCmdVld, oRdCmdRdy;
    logic [19:0] iRdCmdPld;
    logic [3:0]  iRdCmdDst;
    logic        oRdDataVld, iRdDataRdy;
    logic [32:0] oRdDataPld;
    logic [3:0]  oRdDataDst;
    logic        oFreeVld, iFreeRdy;
    logic [10:0] oFreePld;
    logic        oDataRdEn;
    logic [13:0] oDataRdAddr;
    logic [31:0] data_q;
    logic        oPtrRdEn;
    logic [10:0] oPtrRdAddr;
    logic [10:0] ptr_q;
    logic [10:0] ptr_mem [0:2047];

    int tests = 0, fails = 0;
    int cyc = 0, issued = 0, accepted = 0, max_out = 0;
    int vld_seen = 0, rden_seen = 0, stab_err = 0;
    logic [32:0] beats[$];
    logic [3:0]  beat_dst[$];
    int          beat_cyc[$];
    logic [10:0] frees[$];
    logic        p_dvld, p_drdy, p_fvld, p_frdy;
    logic [32:0] p_dpld;
    logic [10:0] p_fpld;

    pkt_rd_engine #(.DW(32), .AW(11), .PAGE_BEATS(8)) dut (
        .iClk(clk), .iRst_n(rst_n),
        .iRdCmdVld(iRdCmdVld), .oRdCmdRdy(oRdCmdRdy), .iRdCmdPld(iRdCmdPld), .iRdCmdDst(iRdCmdDst),
        .oRdDataVld(oRdDataVld), .iRdDataRdy(iRdDataRdy), .oRdDataPld(oRdDataPld), .oRdDataDst(oRdDataDst),
        .oFreeVld(oFreeVld), .iFreeRdy(iFreeRdy), .oFreePld(oFreePld),
        .oDataRdEn(oDataRdEn), .oDataRdAddr(oDataRdAddr), .iDataRdData(data_q),
        .oPtrRdEn(oPtrRdEn), .oPtrRdAddr(oPtrRdAddr), .iPtrRdData(ptr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dword(input logic [13:0] a);
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    // Synchronous SRAM models: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (oDataRdEn) data_q <= dword(oDataRdAddr);
        if (oPtrRdEn)  ptr_q  <= ptr_mem[oPtrRdAddr];
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            p_dvld = 1'b0; p_fvld = 1'b0; issued = 0; accepted = 0;
        end else begin
            if (oDataRdEn) begin issued++; rden_seen++; end
            if (oRdDataVld) vld_seen++;
            if (p_dvld && !p_drdy && (!oRdDataVld || oRdDataPld !== p_dpld)) stab_err++;
            if (p_fvld && !p_frdy && (!oFreeVld || oFreePld !== p_fpld)) stab_err++;
            if (oRdDataVld && iRdDataRdy) begin
                beats.push_back(oRdDataPld);
                beat_dst.push_back(oRdDataDst);
                beat_cyc.push_back(cyc);
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (oFreeVld && iFreeRdy) frees.push_back(oFreePld);
            p_dvld = oRdDataVld; p_drdy = iRdDataRdy; p_dpld = oRdDataPld;
            p_fvld = oFreeVld;   p_frdy = iFreeRdy;   p_fpld = oFreePld;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear();
        beats.delete(); beat_dst.delete(); beat_cyc.delete(); frees.delete();
        max_out = 0; vld_seen = 0; rden_seen = 0; stab_err = 0;
    endtask

    task automatic send_cmd(input logic [10:0] fir, input logic [3:0] cnt, input logic [3:0] dst, input logic drop);
        @(posedge clk); #1;
        iRdCmdVld = 1'b1;
        iRdCmdPld = {fir, cnt, dst, drop};
        iRdCmdDst = 4'hF;
        tick();
        check("cmd_rdy", oRdCmdRdy, 1'b1);
        @(posedge clk); #1;
        iRdCmdVld = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int nb, input int nf, input int mode);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (mode == 1) iRdDataRdy = (k >= 6 && k < 11) ? 1'b0 : k[0];
            tick();
            if (beats.size() >= nb && frees.size() >= nf && oRdCmdRdy) begin
                ok = 1'b1;
                break;
            end
        end
        iRdDataRdy = 1'b1;
        check({nm, "_done"}, ok, 1'b1);
    endtask

    task automatic check_pkt(input string nm, input int npg, input logic [10:0] p0, input logic [10:0] p1,
                             input logic [10:0] p2, input logic [3:0] dst);
        logic [10:0] pg;
        logic [32:0] exp, got;
        int n, dst_bad;
        n = npg * 8;
        dst_bad = 0;
        check({nm, "_nbeats"}, beats.size(), n);
        for (int i = 0; i < n; i++) begin
            pg  = (i < 8) ? p0 : (i < 16) ? p1 : p2;
            exp = {dword({pg, i[2:0]}), (i == n - 1)};
            got = (i < beats.size()) ? beats[i] : 'x;
            check($sformatf("%s_beat%0d", nm, i), got, exp);
            if (i < beat_dst.size() && beat_dst[i] !== dst) dst_bad++;
        end
        check({nm, "_dst"}, dst_bad, 0);
        check({nm, "_nfree"}, frees.size(), npg);
        for (int i = 0; i < npg && i < frees.size(); i++)
            check($sformatf("%s_free%0d", nm, i), frees[i], (i == 0) ? p0 : (i == 1) ? p1 : p2);
        check({nm, "_stable"}, stab_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ptr_mem[i] = 11'h000;
        ptr_mem[11'h010] = 11'h2A5;
        ptr_mem[11'h2A5] = 11'h003;
        ptr_mem[11'h040] = 11'h041;
        rst_n = 1'b0; iRdCmdVld = 1'b0; iRdCmdPld = '0; iRdCmdDst = '0;
        iRdDataRdy = 1'b1; iFreeRdy = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        check("rst_cmd_rdy", oRdCmdRdy, 1'b1);
        check("rst_data_vld", oRdDataVld, 1'b0);
        check("rst_free_vld", oFreeVld, 1'b0);
        check("rst_data_rden", oDataRdEn, 1'b0);
        check("rst_ptr_rden", oPtrRdEn, 1'b0);
        check("rst_addrs", {oDataRdAddr, oPtrRdAddr, oFreePld}, '0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single page with latency checks
        clear();
        send_cmd(11'h010, 4'd0, 4'd3, 1'b0);
        tick();
        check("t1_rden_T1", oDataRdEn, 1'b1);
        check("t1_addr_T1", oDataRdAddr, 14'h080);
        tick();
        check("t1_vld_T2", oRdDataVld, 1'b1);
        check("t1_pld_T2", oRdDataPld, {dword(14'h080), 1'b0});
        wait_done("t1", 8, 1, 0);
        check_pkt("t1", 1, 11'h010, 11'h000, 11'h000, 4'd3);
        check("t1_idle_after_last", cyc - beat_cyc[beat_cyc.size() - 1], 1);

        // Three-page chain, full throughput
        clear();
        send_cmd(11'h010, 4'd2, 4'd7, 1'b0);
        wait_done("t2", 24, 3, 0);
        check_pkt("t2", 3, 11'h010, 11'h2A5, 11'h003, 4'd7);
        check("t2_no_gap", beat_cyc[beat_cyc.size() - 1] - beat_cyc[0], 23);

        // Same chain under data backpressure
        clear();
        iRdDataRdy = 1'b0;
        send_cmd(11'h010, 4'd2, 4'd1, 1'b0);
        wait_done("t3", 24, 3, 1);
        check_pkt("t3", 3, 11'h010, 11'h2A5, 11'h003, 4'd1);
        check("t3_max_outstanding_le2", max_out <= 2, 1'b1);

        // Drop: frees only
        clear();
        send_cmd(11'h040, 4'd1, 4'd2, 1'b1);
        wait_done("t4", 0, 2, 0);
        check("t4_no_data_vld", vld_seen, 0);
        check("t4_no_rden", rden_seen, 0);
        check("t4_nfree", frees.size(), 2);
        check("t4_free0", frees[0], 11'h040);
        check("t4_free1", frees[1], 11'h041);
        check("t4_cmd_rdy", oRdCmdRdy, 1'b1);

        // Free backpressure across the page boundaries
        clear();
        iFreeRdy = 1'b0;
        send_cmd(11'h010, 4'd1, 4'd4, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        tick();
        check("t5_stall_rden", oDataRdEn, 1'b0);
        check("t5_free_vld", oFreeVld, 1'b1);
        check("t5_free_pld", oFreePld, 11'h010);
        check("t5_beats_before_release", beats.size(), 15);
        @(posedge clk); #1; iFreeRdy = 1'b1;
        wait_done("t5", 16, 2, 0);
        check_pkt("t5", 2, 11'h010, 11'h2A5, 11'h000, 4'd4);

        // Reset mid-packet, then a fresh command
        clear();
        send_cmd(11'h010, 4'd2, 4'd6, 1'b0);
        for (int k = 0; k < 100 && beats.size() < 12; k++) tick();
        check("t6_reached_beat12", beats.size(), 12);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cmd_rdy", oRdCmdRdy, 1'b1);
        check("t6_rst_data_vld", oRdDataVld, 1'b0);
        check("t6_rst_free_vld", oFreeVld, 1'b0);
        check("t6_rst_rden", {oDataRdEn, oPtrRdEn}, 2'b00);
        check("t6_nfree_at_rst", frees.size(), 1);
        @(posedge clk); #1; rst_n = 1'b1;
        clear();
        send_cmd(11'h2A5, 4'd0, 4'd5, 1'b0);
        wait_done("t6b", 8, 1, 0);
        check_pkt("t6b", 1, 11'h2A5, 11'h000, 11'h000, 4'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
